// File: rtl/mod_det_nxn_if.sv
// rtl/mod_det_nxn_if.sv - request/result bundle for the NxN determinant engine
interface mod_det_nxn_if #(
    parameter int W     = 8,
    parameter int OUT_W = 16
);
    logic              start;
    logic [2:0]        tamanho;
    logic [16*W-1:0]   matriz;
    logic [OUT_W-1:0]  resultado;
    logic              done;
    logic              busy;
    logic              erro;
    logic              overflow;

    modport master (
        output start, tamanho, matriz,
        input  resultado, done, busy, erro, overflow
    );

    modport slave (
        input  start, tamanho, matriz,
        output resultado, done, busy, erro, overflow
    );
endinterface

// File: rtl/mod_det_nxn.sv
// rtl/mod_det_nxn.sv - sequential Leibniz determinant engine for 2x2/3x3/4x4, optional DET_SAT_EN saturation
module mod_det_nxn #(
    parameter int W         = 8,
    parameter int OUT_W     = 16,
    parameter int SIGNED_EL = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    mod_det_nxn_if.slave bus
);
    localparam int EXT_W  = W + 1;
    localparam int PROD_W = 4 * EXT_W;
    localparam int ACC_W  = PROD_W + 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIM  = 2'd2;

    localparam logic signed [ACC_W-1:0] RES_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] RES_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [1:0]              state_q, state_d;
    logic [16*W-1:0]         mat_q, mat_d;
    logic [2:0]              size_q, size_d;
    logic [4:0]              cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0]        res_q, res_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    erro_q, erro_d;
    logic                    ovf_q, ovf_d;

    logic [8:0]              entry;
    logic [1:0]              col;
    logic [W-1:0]            el;
    logic signed [EXT_W-1:0] fac;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    ovf_c;
    logic [OUT_W-1:0]        res_c;
    logic [4:0]              last_idx;
    logic                    size_ok;

    // Permutations of {0..3} as {odd, p3, p2, p1, p0}. Ordered so that the first
    // 2 entries fix rows 2..3 and the first 6 fix row 3: a size-k run simply walks
    // the first k! entries, and fixed points leave the parity unchanged.
    function automatic logic [8:0] perm_entry(input logic [4:0] idx);
        case (idx)
            5'd0:    perm_entry = {1'b0, 2'd3, 2'd2, 2'd1, 2'd0};
            5'd1:    perm_entry = {1'b1, 2'd3, 2'd2, 2'd0, 2'd1};
            5'd2:    perm_entry = {1'b1, 2'd3, 2'd1, 2'd2, 2'd0};
            5'd3:    perm_entry = {1'b0, 2'd3, 2'd1, 2'd0, 2'd2};
            5'd4:    perm_entry = {1'b0, 2'd3, 2'd0, 2'd2, 2'd1};
            5'd5:    perm_entry = {1'b1, 2'd3, 2'd0, 2'd1, 2'd2};
            5'd6:    perm_entry = {1'b1, 2'd2, 2'd3, 2'd1, 2'd0};
            5'd7:    perm_entry = {1'b0, 2'd2, 2'd3, 2'd0, 2'd1};
            5'd8:    perm_entry = {1'b0, 2'd2, 2'd1, 2'd3, 2'd0};
            5'd9:    perm_entry = {1'b1, 2'd2, 2'd1, 2'd0, 2'd3};
            5'd10:   perm_entry = {1'b1, 2'd2, 2'd0, 2'd3, 2'd1};
            5'd11:   perm_entry = {1'b0, 2'd2, 2'd0, 2'd1, 2'd3};
            5'd12:   perm_entry = {1'b0, 2'd1, 2'd3, 2'd2, 2'd0};
            5'd13:   perm_entry = {1'b1, 2'd1, 2'd3, 2'd0, 2'd2};
            5'd14:   perm_entry = {1'b1, 2'd1, 2'd2, 2'd3, 2'd0};
            5'd15:   perm_entry = {1'b0, 2'd1, 2'd2, 2'd0, 2'd3};
            5'd16:   perm_entry = {1'b0, 2'd1, 2'd0, 2'd3, 2'd2};
            5'd17:   perm_entry = {1'b1, 2'd1, 2'd0, 2'd2, 2'd3};
            5'd18:   perm_entry = {1'b1, 2'd0, 2'd3, 2'd2, 2'd1};
            5'd19:   perm_entry = {1'b0, 2'd0, 2'd3, 2'd1, 2'd2};
            5'd20:   perm_entry = {1'b0, 2'd0, 2'd2, 2'd3, 2'd1};
            5'd21:   perm_entry = {1'b1, 2'd0, 2'd2, 2'd1, 2'd3};
            5'd22:   perm_entry = {1'b1, 2'd0, 2'd1, 2'd3, 2'd2};
            5'd23:   perm_entry = {1'b0, 2'd0, 2'd1, 2'd2, 2'd3};
            default: perm_entry = {1'b0, 2'd3, 2'd2, 2'd1, 2'd0};
        endcase
    endfunction

    // Signed product of one permutation term; rows beyond the matrix order contribute +1
    always_comb begin
        entry = perm_entry(cnt_q);
        prod  = {{(PROD_W-1){1'b0}}, 1'b1};
        col   = 2'd0;
        el    = '0;
        fac   = '0;
        for (int r = 0; r < 4; r++) begin
            col = entry[2*r +: 2];
            el  = mat_q[(4*r + int'(col))*W +: W];
            fac = (SIGNED_EL != 0) ? {el[W-1], el} : {1'b0, el};
            if (r >= int'(size_q)) begin
                fac = {{(EXT_W-1){1'b0}}, 1'b1};
            end
            prod = prod * PROD_W'(fac);
        end
        term = ACC_W'(prod);
        if (entry[8]) begin
            term = -term;
        end
        acc_sum = acc_q + term;
        ovf_c   = (acc_sum > RES_MAX) || (acc_sum < RES_MIN);
`ifdef DET_SAT_EN
        if (ovf_c) begin
            res_c = acc_sum[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            res_c = acc_sum[OUT_W-1:0];
        end
`else
        res_c = acc_sum[OUT_W-1:0];
`endif
    end

    // Control: accept requests in IDLE, accumulate k! terms in CALC, publish in FIM
    always_comb begin
        state_d  = state_q;
        mat_d    = mat_q;
        size_d   = size_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        res_d    = res_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        erro_d   = erro_q;
        ovf_d    = ovf_q;
        size_ok  = (bus.tamanho == 3'd2) || (bus.tamanho == 3'd3) || (bus.tamanho == 3'd4);
        last_idx = (size_q == 3'd2) ? 5'd1 : ((size_q == 3'd3) ? 5'd5 : 5'd23);
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (size_ok) begin
                        mat_d   = bus.matriz;
                        size_d  = bus.tamanho;
                        cnt_d   = 5'd0;
                        acc_d   = '0;
                        erro_d  = 1'b0;
                        ovf_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_CALC;
                    end else begin
                        done_d  = 1'b1;
                        erro_d  = 1'b1;
                        res_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
            end
            S_CALC: begin
                acc_d = acc_sum;
                if (cnt_q == last_idx) begin
                    res_d   = res_c;
                    ovf_d   = ovf_c;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FIM;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_FIM: begin
                cnt_d   = 5'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any computation without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mat_q   <= '0;
            size_q  <= 3'd0;
            cnt_q   <= 5'd0;
            acc_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            erro_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mat_q   <= mat_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            erro_q  <= erro_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.resultado = res_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.erro      = erro_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_mod_det_nxn.sv
// tb/tb_mod_det_nxn.sv - directed bench for mod_det_nxn (unsigned and signed instances)
module tb_mod_det_nxn;
    localparam int W     = 8;
    localparam int OUT_W = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            tb_start;
    logic [2:0]      tb_tam;
    logic [16*W-1:0] tb_mat;
    int              n_tests = 0;
    int              n_fail = 0;
    int              edge_no = 0;
    int              acc_edge = 0;
    bit              chk_en = 1'b0;

    always #5 clk = ~clk;

    mod_det_nxn_if #(.W(W), .OUT_W(OUT_W)) if_u ();
    mod_det_nxn_if #(.W(W), .OUT_W(OUT_W)) if_s ();

    assign if_u.start   = tb_start;
    assign if_u.tamanho = tb_tam;
    assign if_u.matriz  = tb_mat;
    assign if_s.start   = tb_start;
    assign if_s.tamanho = tb_tam;
    assign if_s.matriz  = tb_mat;

    mod_det_nxn #(.W(W), .OUT_W(OUT_W), .SIGNED_EL(0)) u_dut_u (.clk(clk), .rst_n(rst_n), .bus(if_u));
    mod_det_nxn #(.W(W), .OUT_W(OUT_W), .SIGNED_EL(1)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint det3(input longint a[4][4], input int r0, input int r1, input int r2,
                                    input int c0, input int c1, input int c2);
        return a[r0][c0] * (a[r1][c1]*a[r2][c2] - a[r1][c2]*a[r2][c1])
             - a[r0][c1] * (a[r1][c0]*a[r2][c2] - a[r1][c2]*a[r2][c0])
             + a[r0][c2] * (a[r1][c0]*a[r2][c1] - a[r1][c1]*a[r2][c0]);
    endfunction

    // Reference determinant by cofactor expansion over the top-left k x k block
    function automatic longint det_of(input logic [16*W-1:0] m, input logic [2:0] k, input bit sgn);
        longint   a[4][4];
        longint   d;
        int       cs[3];
        int       p;
        logic [7:0] v;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                v = m[(4*r+c)*8 +: 8];
                a[r][c] = sgn ? longint'($signed(v)) : longint'({56'd0, v});
            end
        end
        d = 0;
        if (k == 3'd2) begin
            d = a[0][0]*a[1][1] - a[0][1]*a[1][0];
        end else if (k == 3'd3) begin
            d = det3(a, 0, 1, 2, 0, 1, 2);
        end else begin
            for (int j = 0; j < 4; j++) begin
                p = 0;
                for (int c = 0; c < 4; c++) begin
                    if (c != j) begin
                        cs[p] = c;
                        p++;
                    end
                end
                d += ((j % 2) != 0 ? -1 : 1) * a[0][j] * det3(a, 1, 2, 3, cs[0], cs[1], cs[2]);
            end
        end
        return d;
    endfunction

    function automatic logic ovf_of(input longint d);
        return (d > 32767) || (d < -32768);
    endfunction

    function automatic logic [15:0] res_of(input longint d);
`ifdef DET_SAT_EN
        if (d > 32767) return 16'h7FFF;
        if (d < -32768) return 16'h8000;
`endif
        return d[15:0];
    endfunction

    function automatic logic [16*W-1:0] mk(input int v[16]);
        logic [16*W-1:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) m[i*8 +: 8] = 8'(v[i]);
        return m;
    endfunction

    // Behavioural model: a request of order k occupies k! compute cycles plus one result cycle
    logic [15:0] m_res_u, m_res_s;
    logic        m_ovf_u, m_ovf_s, m_done, m_busy, m_erro;
    longint      pend_u, pend_s;
    int          left;

    always @(posedge clk) edge_no <= edge_no + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_res_u <= '0; m_res_s <= '0; m_ovf_u <= 1'b0; m_ovf_s <= 1'b0;
            m_done <= 1'b0; m_busy <= 1'b0; m_erro <= 1'b0; left <= 0;
        end else begin
            m_done <= 1'b0;
            if (left > 0) begin
                left <= left - 1;
                if (left == 2) begin
                    m_busy  <= 1'b0;
                    m_done  <= 1'b1;
                    m_res_u <= res_of(pend_u);
                    m_res_s <= res_of(pend_s);
                    m_ovf_u <= ovf_of(pend_u);
                    m_ovf_s <= ovf_of(pend_s);
                end
            end else if (tb_start) begin
                if (tb_tam inside {3'd2, 3'd3, 3'd4}) begin
                    left    <= ((tb_tam == 3'd2) ? 2 : ((tb_tam == 3'd3) ? 6 : 24)) + 1;
                    m_busy  <= 1'b1;
                    m_erro  <= 1'b0;
                    m_ovf_u <= 1'b0;
                    m_ovf_s <= 1'b0;
                    pend_u  <= det_of(tb_mat, tb_tam, 1'b0);
                    pend_s  <= det_of(tb_mat, tb_tam, 1'b1);
                end else begin
                    m_done  <= 1'b1;
                    m_erro  <= 1'b1;
                    m_res_u <= '0;
                    m_res_s <= '0;
                    m_ovf_u <= 1'b0;
                    m_ovf_s <= 1'b0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("res_u",  64'(if_u.resultado), 64'(m_res_u));
            chk("res_s",  64'(if_s.resultado), 64'(m_res_s));
            chk("ovf_u",  64'(if_u.overflow),  64'(m_ovf_u));
            chk("ovf_s",  64'(if_s.overflow),  64'(m_ovf_s));
            chk("done_u", 64'(if_u.done),      64'(m_done));
            chk("done_s", 64'(if_s.done),      64'(m_done));
            chk("busy_u", 64'(if_u.busy),      64'(m_busy));
            chk("busy_s", 64'(if_s.busy),      64'(m_busy));
            chk("erro_u", 64'(if_u.erro),      64'(m_erro));
            chk("erro_s", 64'(if_s.erro),      64'(m_erro));
        end
    end

    task automatic pulse(input logic [2:0] tam, input logic [16*W-1:0] m);
        @(posedge clk); #2;
        tb_start = 1'b1;
        tb_tam   = tam;
        tb_mat   = m;
        @(posedge clk); #2;
        acc_edge = edge_no;
        tb_start = 1'b0;
    endtask

    // Returns the cycle (relative to acceptance) in which done rose, 0 on timeout
    task automatic wait_done(input int maxc, output int n, output int nb);
        n  = 0;
        nb = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (if_u.busy) nb++;
            if (if_u.done) begin
                n = edge_no - acc_edge + 1;
                break;
            end
        end
    endtask

    logic [16*W-1:0] m1, m2x2, m3x3, mdiag, mp, mq, mr, mneg, mdense;
    int n, nb, ndone;

    initial begin
        tb_start = 1'b0;
        tb_tam   = 3'd0;
        tb_mat   = '0;
        m1     = mk('{1,2,3,4, 5,6,7,8, 2,6,4,8, 3,1,1,2});
        m2x2   = mk('{-3,5,0,0, 2,7,0,0, 0,0,0,0, 0,0,0,0});
        m3x3   = mk('{2,0,1,99, 1,3,2,99, 1,1,4,99, 99,99,99,99});
        mdiag  = mk('{127,0,0,0, 0,127,0,0, 0,0,127,0, 0,0,0,127});
        mp     = mk('{200,100,0,0, 100,200,0,0, 0,0,0,0, 0,0,0,0});
        mq     = mk('{255,0,0,0, 0,255,0,0, 0,0,0,0, 0,0,0,0});
        mr     = mk('{-128,0,0,0, 0,-128,0,0, 0,0,-128,0, 0,0,0,127});
        mneg   = mk('{-128,0,0,0, 0,-128,0,0, 0,0,-128,0, 0,0,0,-128});
        mdense = mk('{-5,3,7,-2, 4,-6,1,8, 9,2,-7,3, -1,5,6,-4});

        repeat (2) @(posedge clk);
        #2;
        chk("rst_res",  64'(if_s.resultado), 64'd0);
        chk("rst_busy", 64'(if_u.busy), 64'd0);
        chk("rst_done", 64'(if_s.done), 64'd0);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        pulse(3'd4, m1);
        wait_done(40, n, nb);
        chk("t1_lat", 64'(n), 64'd25);
        chk("t1_busy_cycles", 64'(nb), 64'd24);
        chk("t1_res_u", 64'(if_u.resultado), 64'd72);
        chk("t1_res_s", 64'(if_s.resultado), 64'd72);

        pulse(3'd2, m2x2);
        wait_done(40, n, nb);
        chk("t2_lat", 64'(n), 64'd3);
        chk("t2_res_s", 64'(if_s.resultado), 64'hFFE1);
        chk("t2_res_u", 64'(if_u.resultado), 64'h06E1);

        pulse(3'd3, m3x3);
        wait_done(40, n, nb);
        chk("t3_lat", 64'(n), 64'd7);
        chk("t3_res_s", 64'(if_s.resultado), 64'd18);

        pulse(3'd4, mdiag);
        wait_done(40, n, nb);
        chk("t4_ovf_s", 64'(if_s.overflow), 64'd1);
        chk("t4_ovf_u", 64'(if_u.overflow), 64'd1);
`ifdef DET_SAT_EN
        chk("t4_res_s", 64'(if_s.resultado), 64'h7FFF);
`else
        chk("t4_res_s", 64'(if_s.resultado), 64'h7E01);
`endif

        pulse(3'd5, m1);
        wait_done(10, n, nb);
        chk("t5_lat", 64'(n), 64'd1);
        chk("t5_erro", 64'(if_u.erro), 64'd1);
        chk("t5_res", 64'(if_s.resultado), 64'd0);
        chk("t5_ovf", 64'(if_s.overflow), 64'd0);
        foreach (m1[i]) begin end
        for (int t = 0; t < 8; t++) begin
            if (t == 2 || t == 3 || t == 4) continue;
            pulse(3'(t), m2x2);
            wait_done(10, n, nb);
            chk("inv_lat", 64'(n), 64'd1);
        end
        pulse(3'd2, m2x2);
        @(negedge clk);
        chk("t5_erro_clr", 64'(if_s.erro), 64'd0);
        wait_done(40, n, nb);
        chk("t5_lat2", 64'(n), 64'd3);

        pulse(3'd4, m1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (edge_no - acc_edge + 1 == 10) break;
        end
        tb_start = 1'b1;
        tb_tam   = 3'd2;
        tb_mat   = mdiag;
        @(posedge clk); #2;
        tb_start = 1'b0;
        wait_done(40, n, nb);
        chk("t6_lat", 64'(n), 64'd25);
        chk("t6_res", 64'(if_u.resultado), 64'd72);

        tb_start = 1'b1;
        tb_tam   = 3'd2;
        tb_mat   = m2x2;
        @(posedge clk); #2;
        chk("fim_start_ignored", 64'(if_s.busy), 64'd0);
        @(posedge clk); #2;
        acc_edge = edge_no;
        tb_start = 1'b0;
        chk("idle_start_accepted", 64'(if_s.busy), 64'd1);
        wait_done(40, n, nb);
        chk("t7_lat", 64'(n), 64'd3);
        chk("t7_res_s", 64'(if_s.resultado), 64'hFFE1);

        pulse(3'd4, m1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (edge_no - acc_edge + 1 == 12) break;
        end
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_res", 64'(if_s.resultado), 64'd0);
        chk("rst_mid_busy", 64'(if_s.busy), 64'd0);
        chk("rst_mid_done", 64'(if_u.done), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (if_u.done || if_s.done) ndone++;
        end
        chk("rst_no_done", 64'(ndone), 64'd0);
        pulse(3'd3, m3x3);
        wait_done(40, n, nb);
        chk("t8_lat", 64'(n), 64'd7);
        chk("t8_res", 64'(if_u.resultado), 64'd18);

        pulse(3'd2, mp);
        wait_done(40, n, nb);
        chk("t9_res_u", 64'(if_u.resultado), 64'h7530);
        chk("t9_res_s", 64'(if_s.resultado), 64'hE530);

        pulse(3'd2, mq);
        wait_done(40, n, nb);
        chk("t10_ovf_u", 64'(if_u.overflow), 64'd1);
        chk("t10_ovf_s", 64'(if_s.overflow), 64'd0);
        chk("t10_res_s", 64'(if_s.resultado), 64'd1);
`ifdef DET_SAT_EN
        chk("t10_res_u", 64'(if_u.resultado), 64'h7FFF);
`else
        chk("t10_res_u", 64'(if_u.resultado), 64'hFE01);
`endif

        pulse(3'd4, mr);
        wait_done(40, n, nb);
        pulse(3'd4, mneg);
        wait_done(40, n, nb);
        pulse(3'd4, mdense);
        wait_done(40, n, nb);
        pulse(3'd3, mdense);
        wait_done(40, n, nb);
        chk("t11_lat", 64'(n), 64'd7);

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end
endmodule
